aes_key_expander: RTL
=====================

# aes_key_expander

Sequential AES key-schedule engine supporting AES-128, AES-192 and AES-256, selected per operation. It replaces the single-step combinational round-key calculation with an iterative expander. The expander generates one 32-bit schedule word per clock through a four-S-box SubWord datapath, and stores the complete schedule in an internal round-key file. Cipher and inverse-cipher round controllers read any round key, in any order, by index, which allows reverse-order access for decryption.

## Interface
- MAX_KEY_BITS, 256: largest key length supported (128, 192 or 256). It sizes the round-key file to 4*(MAX_NR+1) words, where MAX_NR is 10, 12 or 14. Modes above this size are rejected.
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new expansion; sampled only in IDLE.
- key_len  in  2  0=128, 1=192, 2=256, 3=illegal.
- key_in  in  256  cipher key, MSB-first. w0=key_in[255:224]. For 128/192-bit keys, only the top 128/192 bits are used.
- busy  out  1  high in EXPAND.
- done  out  1  one-cycle pulse when the schedule is complete.
- key_ready  out  1  level, high while a complete schedule is held.
- err  out  1  one-cycle pulse on a rejected start.
- nr  out  4  round count of the held schedule (10/12/14).
- rk_idx  in  4  round-key index, 0..nr.
- rk_out  out  128  registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, where r=rk_idx.

## Operation
- States: IDLE, EXPAND.
  - IDLE: start=1 with a legal key_len ≤ MAX_KEY_BITS takes the machine to EXPAND.
  - IDLE: start=1 with key_len=3, or a length > MAX_KEY_BITS, pulses err the next cycle and stays in IDLE. key_ready and the stored keys are unchanged.
  - EXPAND: returns to IDLE after the last word is written.
- On acceptance:
  - Latch Nk (4/6/8) and Nr=Nk+6; nr updates immediately.
  - Total word count T=4*(Nr+1), i.e. 44/52/60.
  - Write w0..w(Nk-1) into the file and into an 8-word sliding window.
  - Clear key_ready. Set rcon=8'h01, i=Nk, and phase counter j=0 (j = i mod Nk).
- Each EXPAND cycle computes word i, with temp=w[i-1] and w[i-Nk] taken from the window, never from the file:
  - j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}. Then rcon <= xtime(rcon), i.e. shift left 1 and XOR 8'h1B if bit 7 was set.
  - Nk==8 and j==4: temp = SubWord(temp).
  - Otherwise temp is unchanged.
  - w[i] = w[i-Nk] ^ temp.
  - Write w[i] to the file and shift it into the window.
  - Increment i. j wraps from Nk-1 to 0.
- RotWord rotates left by one byte. SubWord applies the standard AES S-box to each of the 4 bytes, using 4 instances total.
- When i==T-1 is written:
  - Next cycle: done=1, key_ready=1, busy=0, state IDLE.
- start during EXPAND is ignored; no err is raised.
- rk_out:
  - rk_idx > nr gives rk_out=0.
  - While key_ready=0, rk_out is don't-care and must not be consumed.
- Reset mid-expansion:
  - Immediately returns to IDLE.
  - Clears key_ready, which forces re-expansion.

## Timing
- Reset values: busy=0, done=0, err=0, key_ready=0, nr=0, rk_out=0, state IDLE. File contents are don't-care.
- Start accepted at edge 0. Words Nk..T-1 are written at edges 1..T-Nk. done and key_ready are high after edge T-Nk+1.
  - AES-128: done at cycle 41.
  - AES-192: done at cycle 47.
  - AES-256: done at cycle 53.
- rk_out latency is 1 cycle: rk_idx sampled at edge n gives data valid after edge n.
- A new start may be accepted in the same cycle that done is high, because the state is already IDLE. It clears key_ready at that edge.
- err is a single cycle, registered, and asserted one cycle after the rejected start.
- Critical path: window mux → S-box → XOR; this path is unpipelined.

## Test plan
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c: done exactly 41 cycles after start. rk_idx=1 gives a0fafe17 88542cb1 23a33939 2a6c7605; rk_idx=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6; nr=10.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b: done at cycle 47; rk_idx=12 gives e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4: done at cycle 53; rk_idx=14 gives fe4890d1 e6188d0b 046df344 706c631e; rk_idx=0 returns the first 128 key bits.
- Rejection and index range:
  - key_len=3 gives an err pulse with no busy.
  - With MAX_KEY_BITS=128, key_len=2 also gives err.
  - With a schedule held, rk_idx=15 gives rk_out=0.
- Reverse-order readout: sweep rk_idx 14 down to 0 and check each round key against the model.
- Start during busy is ignored.
- rst_n low at cycle 20 of an AES-256 expansion: outputs return to reset values asynchronously. A subsequent AES-128 run then completes correctly in 41 cycles.

Source files
------------

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into a
// round-key file that is read back by index with one cycle of latency.
module aes_key_expander #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    output logic         err,
    output logic [3:0]   nr,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    localparam int        MAX_NR     = MAX_KEY_BITS / 32 + 6;
    localparam int        FILE_WORDS = 4 * (MAX_NR + 1);
    localparam logic [9:0] MAX_BITS  = 10'(MAX_KEY_BITS);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        S_IDLE,
        S_EXPAND
    } state_t;

    // Entry b sits at the top bit 8*(255-b)+7, which is {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        r_state, w_next_state;
    logic [2:0]    r_nk_m1;
    logic [3:0]    r_nr;
    logic [5:0]    r_i;
    logic [2:0]    r_j;
    logic [7:0]    r_rcon;
    logic          r_done, r_err, r_key_ready;
    logic [127:0]  r_rk_out;
    logic [31:0]   r_win  [8];
    logic [31:0]   r_file [FILE_WORDS];

    logic          w_accept, w_reject, w_step, w_finish, w_legal;
    logic [9:0]    w_keybits;
    logic [2:0]    w_nkm1_new;
    logic [3:0]    w_nr_new;
    logic [5:0]    w_total;
    logic [31:0]   w_key_word [8];
    logic [31:0]   w_win_load [8];
    logic [31:0]   w_prev, w_old, w_sub_in, w_sub, w_temp, w_new;
    logic          w_first, w_nk8_mid;
    logic [5:0]    w_rk_base;
    logic [127:0]  w_rk_word;

    assign w_keybits = 10'd128 + {2'b00, key_len, 6'd0};
    assign w_legal   = (key_len != 2'd3) && (w_keybits <= MAX_BITS);
    assign w_nr_new  = {1'b0, w_nkm1_new} + 4'd7;
    assign w_total   = {r_nr, 2'b00} + 6'd4;

    always_comb begin
        case (key_len)
            2'd0:    w_nkm1_new = 3'd3;
            2'd1:    w_nkm1_new = 3'd5;
            default: w_nkm1_new = 3'd7;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_legal) begin
                        w_accept     = 1'b1;
                        w_next_state = S_EXPAND;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_EXPAND: begin
                // One spare cycle after the last write raises done from IDLE-bound state.
                if (r_i == w_total) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Window holds the newest word at index 0, so w[i-Nk] is at index Nk-1.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_key_word[k] = key_in[255 - 32*k -: 32];
        end
        for (int k = 0; k < 8; k++) begin
            w_win_load[k] = (3'(k) <= w_nkm1_new) ? w_key_word[w_nkm1_new - 3'(k)] : 32'h0;
        end
    end

    assign w_prev    = r_win[0];
    assign w_old     = r_win[r_nk_m1];
    assign w_first   = (r_j == 3'd0);
    assign w_nk8_mid = (r_nk_m1 == 3'd7) && (r_j == 3'd4);
    assign w_sub_in  = w_first ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub     = sub_word(w_sub_in);
    assign w_temp    = w_first   ? (w_sub ^ {r_rcon, 24'h0}) :
                       w_nk8_mid ? w_sub : w_prev;
    assign w_new     = w_old ^ w_temp;

    assign w_rk_base = {rk_idx, 2'b00};
    assign w_rk_word = {r_file[w_rk_base],         r_file[w_rk_base + 6'd1],
                        r_file[w_rk_base + 6'd2],  r_file[w_rk_base + 6'd3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_key_ready <= 1'b0;
            r_nk_m1     <= 3'd0;
            r_nr        <= 4'd0;
            r_i         <= 6'd0;
            r_j         <= 3'd0;
            r_rcon      <= 8'h00;
            r_rk_out    <= 128'h0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_finish;
            r_err   <= w_reject;
            if (w_accept) begin
                r_key_ready <= 1'b0;
                r_nk_m1     <= w_nkm1_new;
                r_nr        <= w_nr_new;
                r_i         <= {3'b000, w_nkm1_new} + 6'd1;
                r_j         <= 3'd0;
                r_rcon      <= 8'h01;
            end else if (w_step) begin
                r_i <= r_i + 6'd1;
                r_j <= (r_j == r_nk_m1) ? 3'd0 : r_j + 3'd1;
                if (w_first) begin
                    r_rcon <= xtime(r_rcon);
                end
            end else if (w_finish) begin
                r_key_ready <= 1'b1;
            end
            r_rk_out <= (r_key_ready && (rk_idx <= r_nr)) ? w_rk_word : 128'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < 8; k++) begin
                r_win[k] <= w_win_load[k];
                if (3'(k) <= w_nkm1_new) begin
                    r_file[k] <= w_key_word[k];
                end
            end
        end else if (w_step) begin
            r_win[0] <= w_new;
            for (int k = 1; k < 8; k++) begin
                r_win[k] <= r_win[k-1];
            end
            r_file[r_i] <= w_new;
        end
    end

    assign busy      = (r_state == S_EXPAND);
    assign done      = r_done;
    assign err       = r_err;
    assign key_ready = r_key_ready;
    assign nr        = r_nr;
    assign rk_out    = r_rk_out;

endmodule
